prog_counter: RTL and testbench

- Parametrised program counter, successor to the 16-bit incrementer.
- Holds the current instruction address and advances it by a configurable step, with optional saturation.
- Supports synchronous clear, absolute load, and call/return through an internal return-address stack.
- Sits between the instruction fetch path and the jump/branch decode.

---
 rtl/prog_counter.sv | 100 ++++++++++
 tb/tb_prog_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Program counter: step increment with optional saturation, absolute load,
// synchronous clear and call/return through a small return-address stack.
module prog_counter #(
  parameter int          WIDTH     = 16,
  parameter int unsigned STEP      = 1,
  parameter int          DEPTH     = 4,
  parameter bit          SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int         SPW       = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic [SPW-1:0]   sp,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_out;
  logic [SPW-1:0]   r_sp;
  logic             r_wrap;
  logic             r_err;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic [AW-1:0]    w_push_idx;
  logic [AW-1:0]    w_pop_idx;

  // One adder serves both inc and the call return address; the return
  // address always takes the modulo result, saturation applies to inc only.
  assign w_sum      = {1'b0, r_out} + (WIDTH+1)'(STEP);
  assign w_carry    = w_sum[WIDTH];
  assign w_full     = (r_sp == SPW'(DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push     = !clr && !ret && call && !w_full;
  assign w_push_idx = AW'(r_sp);
  assign w_pop_idx  = AW'(r_sp - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= RESET_VEC;
      r_sp   <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (clr) begin
        r_out <= RESET_VEC;
        r_sp  <= '0;
      end else if (ret) begin
        if (w_empty) begin
          r_err <= 1'b1;
        end else begin
          r_out <= r_stack[w_pop_idx];
          r_sp  <= r_sp - 1'b1;
        end
      end else if (call) begin
        if (w_full) begin
          r_err <= 1'b1;
        end else begin
          r_out <= in;
          r_sp  <= r_sp + 1'b1;
        end
      end else if (load) begin
        r_out <= in;
      end else if (inc) begin
        r_wrap <= w_carry;
        r_out  <= (SATURATE && w_carry) ? '1 : w_sum[WIDTH-1:0];
      end
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_idx] <= w_sum[WIDTH-1:0];
  end

  assign out         = r_out;
  assign sp          = r_sp;
  assign wrap        = r_wrap;
  assign stack_err   = r_err;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenarios on a wrapping (STEP=1) and a
// saturating (STEP=4) instance, then random strobes against a queue model.
module tb_prog_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 0, load = 0, call = 0, ret = 0, inc = 0;
  logic [15:0] in = '0;

  logic [15:0] out0, out1;
  logic        wrap0, wrap1, full0, full1, empty0, empty1, err0, err1;
  logic [2:0]  sp0, sp1;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prog_counter u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .call(call), .ret(ret),
    .inc(inc), .in(in), .out(out0), .wrap(wrap0), .sp(sp0),
    .stack_full(full0), .stack_empty(empty0), .stack_err(err0)
  );

  prog_counter #(.STEP(4), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .call(call), .ret(ret),
    .inc(inc), .in(in), .out(out1), .wrap(wrap1), .sp(sp1),
    .stack_full(full1), .stack_empty(empty1), .stack_err(err1)
  );

  // Reference model: one entry per instance; the stack is a plain list
  // where push appends and pop takes the last element.
  int unsigned m_out [2];
  int          m_sp  [2];
  int unsigned m_stk [2][4];
  bit          m_wrap[2];
  bit          m_err [2];
  int unsigned m_step[2] = '{1, 4};
  bit          m_sat [2] = '{1'b0, 1'b1};

  task automatic set(input bit c, input bit r, input bit ca, input bit l,
                     input bit i, input logic [15:0] d);
    clr = c; ret = r; call = ca; load = l; inc = i; in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set(0, 0, 0, 0, 0, 16'h0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_out[c] = 0; m_sp[c] = 0; m_wrap[c] = 0; m_err[c] = 0;
    end
  endtask

  task automatic model_step();
    int unsigned s;
    for (int c = 0; c < 2; c++) begin
      m_wrap[c] = 0;
      m_err[c]  = 0;
      if (clr) begin
        m_out[c] = 0; m_sp[c] = 0;
      end else if (ret) begin
        if (m_sp[c] == 0) m_err[c] = 1;
        else begin
          m_sp[c]  = m_sp[c] - 1;
          m_out[c] = m_stk[c][m_sp[c]];
        end
      end else if (call) begin
        if (m_sp[c] == 4) m_err[c] = 1;
        else begin
          m_stk[c][m_sp[c]] = (m_out[c] + m_step[c]) % 65536;
          m_sp[c]  = m_sp[c] + 1;
          m_out[c] = in;
        end
      end else if (load) begin
        m_out[c] = in;
      end else if (inc) begin
        s = m_out[c] + m_step[c];
        if (s > 65535) begin
          m_wrap[c] = 1;
          m_out[c]  = m_sat[c] ? 65535 : s - 65536;
        end else begin
          m_out[c] = s;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set(0, 0, 0, 0, 1, 16'h0);
    repeat (3) tick();
    n_tot++; if (out0 !== 16'h0) begin n_bad++; $display("FAIL reset_out got=%h exp=0000", out0); end
    n_tot++; if (sp0 !== 3'd0) begin n_bad++; $display("FAIL reset_sp got=%0d exp=0", sp0); end
    n_tot++; if ({wrap0, err0, full0, empty0} !== 4'b0001) begin n_bad++; $display("FAIL reset_flags got=%b exp=0001", {wrap0, err0, full0, empty0}); end
    n_tot++; if (out1 !== 16'h0) begin n_bad++; $display("FAIL reset_out1 got=%h exp=0000", out1); end
    set(0, 0, 0, 0, 0, 16'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_inc();
    do_reset();
    set(0, 0, 0, 0, 1, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tot++; if (out0 !== 16'(k)) begin n_bad++; $display("FAIL inc_out%0d got=%h exp=%h", k, out0, 16'(k)); end
      n_tot++; if (wrap0 !== 1'b0) begin n_bad++; $display("FAIL inc_wrap%0d got=%b exp=0", k, wrap0); end
    end
    set(0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic test_wrap();
    set(0, 0, 0, 1, 0, 16'hFFFE); tick();
    set(0, 0, 0, 0, 1, 16'h0);    tick();
    n_tot++; if ({out0, wrap0} !== {16'hFFFF, 1'b0}) begin n_bad++; $display("FAIL wrap_a got=%h/%b exp=ffff/0", out0, wrap0); end
    tick();
    n_tot++; if ({out0, wrap0} !== {16'h0000, 1'b1}) begin n_bad++; $display("FAIL wrap_b got=%h/%b exp=0000/1", out0, wrap0); end
    set(0, 0, 0, 0, 0, 16'h0); tick();
    n_tot++; if ({out0, wrap0} !== {16'h0000, 1'b0}) begin n_bad++; $display("FAIL wrap_c got=%h/%b exp=0000/0", out0, wrap0); end
  endtask

  task automatic test_saturate();
    set(0, 0, 0, 1, 0, 16'hFFFD); tick();
    set(0, 0, 0, 0, 1, 16'h0);    tick();
    n_tot++; if ({out1, wrap1} !== {16'hFFFF, 1'b1}) begin n_bad++; $display("FAIL sat_a got=%h/%b exp=ffff/1", out1, wrap1); end
    n_tot++; if ({out0, wrap0} !== {16'hFFFE, 1'b0}) begin n_bad++; $display("FAIL sat_a0 got=%h/%b exp=fffe/0", out0, wrap0); end
    tick();
    n_tot++; if ({out1, wrap1} !== {16'hFFFF, 1'b1}) begin n_bad++; $display("FAIL sat_b got=%h/%b exp=ffff/1", out1, wrap1); end
    set(0, 0, 0, 0, 0, 16'h0); tick();
    n_tot++; if ({out1, wrap1} !== {16'hFFFF, 1'b0}) begin n_bad++; $display("FAIL sat_c got=%h/%b exp=ffff/0", out1, wrap1); end
  endtask

  task automatic test_stack();
    logic [15:0] exp_ret [4] = '{16'h0101, 16'h0101, 16'h0101, 16'h0011};
    do_reset();
    set(0, 0, 0, 1, 0, 16'h0010); tick();
    for (int k = 1; k <= 4; k++) begin
      set(0, 0, 1, 0, 0, 16'h0100); tick();
      n_tot++; if ({out0, sp0} !== {16'h0100, 3'(k)}) begin n_bad++; $display("FAIL call%0d got=%h/%0d exp=0100/%0d", k, out0, sp0, k); end
    end
    n_tot++; if ({full0, empty0} !== 2'b10) begin n_bad++; $display("FAIL full got=%b exp=10", {full0, empty0}); end
    set(0, 0, 1, 0, 0, 16'h0777); tick();
    n_tot++; if ({out0, sp0, err0} !== {16'h0100, 3'd4, 1'b1}) begin n_bad++; $display("FAIL call_over got=%h/%0d/%b exp=0100/4/1", out0, sp0, err0); end
    for (int k = 0; k < 4; k++) begin
      set(0, 1, 0, 0, 0, 16'h0); tick();
      n_tot++; if ({out0, err0} !== {exp_ret[k], 1'b0}) begin n_bad++; $display("FAIL ret%0d got=%h/%b exp=%h/0", k, out0, err0, exp_ret[k]); end
    end
    tick();
    n_tot++; if ({out0, sp0, err0, empty0} !== {16'h0011, 3'd0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL ret_under got=%h/%0d/%b/%b exp=0011/0/1/1", out0, sp0, err0, empty0); end
    set(0, 0, 0, 0, 0, 16'h0); tick();
    n_tot++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL err_pulse got=%b exp=0", err0); end
  endtask

  task automatic test_priority();
    set(0, 0, 1, 0, 0, 16'h0200); tick(); tick();
    set(1, 1, 0, 1, 0, 16'hABCD); tick();
    n_tot++; if ({out0, sp0, err0} !== {16'h0000, 3'd0, 1'b0}) begin n_bad++; $display("FAIL prio_clr got=%h/%0d/%b exp=0000/0/0", out0, sp0, err0); end
    set(0, 1, 1, 0, 0, 16'h0300); tick();
    n_tot++; if ({out0, sp0, err0} !== {16'h0000, 3'd0, 1'b1}) begin n_bad++; $display("FAIL prio_callret got=%h/%0d/%b exp=0000/0/1", out0, sp0, err0); end
    set(0, 0, 0, 1, 0, 16'hFFFF); tick();
    set(0, 0, 0, 1, 1, 16'h1234); tick();
    n_tot++; if ({out0, wrap0} !== {16'h1234, 1'b0}) begin n_bad++; $display("FAIL prio_loadinc got=%h/%b exp=1234/0", out0, wrap0); end
  endtask

  task automatic test_call_modulo();
    do_reset();
    set(0, 0, 0, 1, 0, 16'hFFFF); tick();
    set(0, 0, 1, 0, 0, 16'h1234); tick();
    n_tot++; if ({out0, wrap0, out1, wrap1} !== {16'h1234, 1'b0, 16'h1234, 1'b0}) begin n_bad++; $display("FAIL callmod_call got=%h/%b %h/%b exp=1234/0 1234/0", out0, wrap0, out1, wrap1); end
    set(0, 1, 0, 0, 0, 16'h0); tick();
    n_tot++; if ({out0, out1} !== {16'h0000, 16'h0003}) begin n_bad++; $display("FAIL callmod_ret got=%h %h exp=0000 0003", out0, out1); end
    set(0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic test_async_reset();
    do_reset();
    set(0, 0, 1, 0, 0, 16'h0100); tick(); tick();
    set(0, 0, 1, 0, 0, 16'h1234); tick();
    set(0, 0, 0, 0, 0, 16'h0);
    #2;
    n_tot++; if ({out0, sp0} !== {16'h1234, 3'd3}) begin n_bad++; $display("FAIL async_pre got=%h/%0d exp=1234/3", out0, sp0); end
    rst_n = 1'b0;
    #1;
    n_tot++; if ({out0, sp0, empty0} !== {16'h0000, 3'd0, 1'b1}) begin n_bad++; $display("FAIL async_rst got=%h/%0d/%b exp=0000/0/1", out0, sp0, empty0); end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] g_out;
    logic [2:0]  g_sp;
    logic        g_wrap, g_err, g_full, g_empty;
    do_reset();
    model_reset();
    for (int n = 0; n < 500; n++) begin
      clr  = ($urandom_range(0, 31) == 0);
      ret  = ($urandom_range(0, 5) == 0);
      call = ($urandom_range(0, 4) == 0);
      load = ($urandom_range(0, 5) == 0);
      inc  = ($urandom_range(0, 1) == 0);
      in   = ($urandom_range(0, 2) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                         : 16'($urandom_range(0, 65535));
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < 2; c++) begin
        g_out   = c ? out1 : out0;
        g_sp    = c ? sp1 : sp0;
        g_wrap  = c ? wrap1 : wrap0;
        g_err   = c ? err1 : err0;
        g_full  = c ? full1 : full0;
        g_empty = c ? empty1 : empty0;
        n_tot++; if (g_out !== 16'(m_out[c])) begin n_bad++; $display("FAIL rnd_out c%0d n%0d got=%h exp=%h", c, n, g_out, 16'(m_out[c])); end
        n_tot++; if (g_sp !== 3'(m_sp[c])) begin n_bad++; $display("FAIL rnd_sp c%0d n%0d got=%0d exp=%0d", c, n, g_sp, m_sp[c]); end
        n_tot++; if ({g_wrap, g_err} !== {m_wrap[c], m_err[c]}) begin n_bad++; $display("FAIL rnd_pulse c%0d n%0d got=%b%b exp=%b%b", c, n, g_wrap, g_err, m_wrap[c], m_err[c]); end
        n_tot++; if ({g_full, g_empty} !== {m_sp[c] == 4, m_sp[c] == 0}) begin n_bad++; $display("FAIL rnd_flags c%0d n%0d got=%b%b exp=%b%b", c, n, g_full, g_empty, m_sp[c] == 4, m_sp[c] == 0); end
      end
    end
    set(0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_saturate();
    test_stack();
    test_priority();
    test_call_modulo();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
